// File: rtl/gmsk_capture_pkg.sv
// ============================================================================
// gmsk_capture_pkg : shared FSM state type and default build constants
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package gmsk_capture_pkg;

  localparam int DEF_BITS     = 16;
  localparam int DEF_COLUMNS  = 2;
  localparam int DEF_ROWS     = 64000;
  localparam int DEF_TICK_DIV = 15625;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TICK = 2'd1,
    ST_EMIT      = 2'd2,
    ST_DONE      = 2'd3
  } cap_state_t;

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sample_tick_gen.sv
// ============================================================================
// sample_tick_gen : modulo-TICK_DIV cycle counter, tick on the last count
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_tick_gen
  import gmsk_capture_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int              CNT_W = idx_width(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

`default_nettype wire

// File: rtl/waveform_capture_scheduler.sv
// ============================================================================
// waveform_capture_scheduler : periodic row capture, serialized column stream
// Optional build macro CAPTURE_OVERRUN_CNT_EN adds a 16-bit dropped-row count.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module waveform_capture_scheduler
  import gmsk_capture_pkg::*;
#(
  parameter int BITS     = DEF_BITS,
  parameter int COLUMNS  = DEF_COLUMNS,
  parameter int ROWS     = DEF_ROWS,
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BITS*COLUMNS-1:0] data,
  output logic [BITS-1:0]         out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
`ifdef CAPTURE_OVERRUN_CNT_EN
  ,
  output logic [15:0]             overrun_cnt
`endif
);

  localparam int              ROW_W    = $clog2(ROWS + 1);
  localparam int              COL_W    = idx_width(COLUMNS);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLUMNS - 1);

  cap_state_t       state, next_state;
  logic [BITS-1:0]  row_buf [COLUMNS];
  logic [ROW_W-1:0] row_cnt;
  logic [COL_W-1:0] col;
  logic             tick;
  logic             tick_clear;
  logic             run_start, capture, col_inc, row_inc, drop;

  assign tick_clear = (state == ST_IDLE) || (state == ST_DONE);

  sample_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (tick_clear),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    run_start  = 1'b0;
    capture    = 1'b0;
    col_inc    = 1'b0;
    row_inc    = 1'b0;
    drop       = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          next_state = ST_WAIT_TICK;
          run_start  = 1'b1;
        end
      end
      ST_WAIT_TICK: begin
        if (tick) begin
          capture    = 1'b1;
          next_state = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (out_ready && (col == LAST_COL)) begin
          row_inc = 1'b1;
          if (row_cnt == LAST_ROW) begin
            next_state = ST_DONE;
          end else if (tick) begin
            capture = 1'b1;
          end else begin
            next_state = ST_WAIT_TICK;
          end
        end else begin
          col_inc = out_ready;
          // A tick while the current row is still draining loses the new row.
          drop    = tick;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt <= '0;
      col     <= '0;
      overrun <= 1'b0;
      for (int j = 0; j < COLUMNS; j++) begin
        row_buf[j] <= '0;
      end
    end else begin
      if (run_start) begin
        row_cnt <= '0;
        col     <= '0;
        overrun <= 1'b0;
      end
      if (capture) begin
        col <= '0;
        for (int j = 0; j < COLUMNS; j++) begin
          row_buf[j] <= data[BITS*j +: BITS];
        end
      end else if (col_inc) begin
        col <= col + 1'b1;
      end
      if (row_inc) begin
        row_cnt <= row_cnt + 1'b1;
      end
      if (drop) begin
        overrun <= 1'b1;
      end
    end
  end

`ifdef CAPTURE_OVERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || run_start) begin
      overrun_cnt <= '0;
    end else if (drop && (overrun_cnt != 16'hFFFF)) begin
      overrun_cnt <= overrun_cnt + 16'd1;
    end
  end
`endif

  assign out_valid = (state == ST_EMIT);
  assign out_last  = out_valid && (col == LAST_COL);
  assign out_data  = out_valid ? row_buf[col] : '0;
  assign busy      = (state == ST_WAIT_TICK) || (state == ST_EMIT);
  assign done      = (state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_waveform_capture_scheduler.sv
// ============================================================================
// tb_waveform_capture_scheduler : directed checks on two scheduler instances
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_waveform_capture_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start4, ready4, start2, ready2;
  logic [31:0] data4, data2;
  logic [15:0] od4, od2;
  logic        ov4, ol4, busy4, done4, orun4;
  logic        ov2, ol2, busy2, done2, orun2;
`ifdef CAPTURE_OVERRUN_CNT_EN
  logic [15:0] ocnt4, ocnt2;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  waveform_capture_scheduler #(
    .BITS(16), .COLUMNS(2), .ROWS(3), .TICK_DIV(4)
  ) dut4 (
    .clk(clk), .rst(rst), .start(start4), .data(data4),
    .out_data(od4), .out_valid(ov4), .out_ready(ready4), .out_last(ol4),
    .busy(busy4), .done(done4), .overrun(orun4)
`ifdef CAPTURE_OVERRUN_CNT_EN
    , .overrun_cnt(ocnt4)
`endif
  );

  waveform_capture_scheduler #(
    .BITS(16), .COLUMNS(2), .ROWS(3), .TICK_DIV(2)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2), .data(data2),
    .out_data(od2), .out_valid(ov2), .out_ready(ready2), .out_last(ol2),
    .busy(busy2), .done(done2), .overrun(orun2)
`ifdef CAPTURE_OVERRUN_CNT_EN
    , .overrun_cnt(ocnt2)
`endif
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid4(input string tag);
    int k = 0;
    while (ov4 !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    check({tag, "_valid_timeout"}, {31'd0, ov4}, 32'd1);
  endtask

  // Waits for a beat on dut4, checks it, then lets the handshake edge pass.
  task automatic expect_beat4(input string tag, input logic [15:0] d, input logic l);
    wait_valid4(tag);
    check({tag, "_data"}, {16'd0, od4}, {16'd0, d});
    check({tag, "_last"}, {31'd0, ol4}, {31'd0, l});
    step();
  endtask

  task automatic pulse_start4();
    start4 = 1'b1;
    step();
    start4 = 1'b0;
  endtask

  task automatic finish_rows4(input string tag, input int rows);
    for (int r = 0; r < rows; r++) begin
      expect_beat4({tag, "_c0"}, 16'hAAAA, 1'b0);
      expect_beat4({tag, "_c1"}, 16'hBBBB, 1'b1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst    = 1'b1;
    start4 = 1'b0;
    start2 = 1'b0;
    ready4 = 1'b1;
    ready2 = 1'b1;
    data4  = 32'hBBBB_AAAA;
    data2  = 32'h2222_1111;
    step();
    step();

    // Reset state
    check("rst_valid",   {31'd0, ov4},   32'd0);
    check("rst_last",    {31'd0, ol4},   32'd0);
    check("rst_data",    {16'd0, od4},   32'd0);
    check("rst_busy",    {31'd0, busy4}, 32'd0);
    check("rst_done",    {31'd0, done4}, 32'd0);
    check("rst_overrun", {31'd0, orun4}, 32'd0);
    rst = 1'b0;
    step();

    // Basic run: 3 rows, no stalls; first beat 4 cycles after the start edge
    pulse_start4();
    check("t1_busy", {31'd0, busy4}, 32'd1);
    check("t1_wait_valid", {31'd0, ov4}, 32'd0);
    k = 0;
    while (ov4 !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    check("t1_latency", k, 32'd4);
    finish_rows4("t1", 3);
    check("t1_done",    {31'd0, done4}, 32'd1);
    check("t1_busy_end",{31'd0, busy4}, 32'd0);
    check("t1_valid_end",{31'd0, ov4},  32'd0);
    check("t1_overrun", {31'd0, orun4}, 32'd0);

    // Backpressure for 2 cycles: first beat holds
    ready4 = 1'b0;
    pulse_start4();
    check("t2_done_cleared", {31'd0, done4}, 32'd0);
    wait_valid4("t2");
    for (int i = 0; i < 3; i++) begin
      check("t2_hold_data",  {16'd0, od4}, 32'h0000_AAAA);
      check("t2_hold_last",  {31'd0, ol4}, 32'd0);
      check("t2_hold_valid", {31'd0, ov4}, 32'd1);
      if (i < 2) step();
    end
    ready4 = 1'b1;
    expect_beat4("t2_r0c0", 16'hAAAA, 1'b0);
    expect_beat4("t2_r0c1", 16'hBBBB, 1'b1);
    finish_rows4("t2", 2);
    check("t2_done",    {31'd0, done4}, 32'd1);
    check("t2_overrun", {31'd0, orun4}, 32'd0);

    // Backpressure for 6 cycles: one tick passes mid-row, that row is dropped
    ready4 = 1'b0;
    pulse_start4();
    wait_valid4("t3");
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i < 6) begin
        check("t3_hold_data", {16'd0, od4}, 32'h0000_AAAA);
        check("t3_hold_last", {31'd0, ol4}, 32'd0);
      end
      if (i == 3) check("t3_overrun_pre",  {31'd0, orun4}, 32'd0);
      if (i == 4) check("t3_overrun_post", {31'd0, orun4}, 32'd1);
    end
    ready4 = 1'b1;
    finish_rows4("t3", 3);
    check("t3_done",           {31'd0, done4}, 32'd1);
    check("t3_overrun_sticky", {31'd0, orun4}, 32'd1);
`ifdef CAPTURE_OVERRUN_CNT_EN
    check("t3_ocnt", {16'd0, ocnt4}, 32'd1);

    // Three drops, then a new start clears the count
    ready4 = 1'b0;
    pulse_start4();
    wait_valid4("t6");
    for (int i = 0; i < 13; i++) step();
    check("t6_ocnt3", {16'd0, ocnt4}, 32'd3);
    ready4 = 1'b1;
    finish_rows4("t6", 3);
    check("t6_done", {31'd0, done4}, 32'd1);
    pulse_start4();
    check("t6_ocnt_clr", {16'd0, ocnt4}, 32'd0);
    check("t6_orun_clr", {31'd0, orun4}, 32'd0);
    finish_rows4("t6b", 3);
`endif

    // TICK_DIV=2: each final handshake meets a tick, rows stream back-to-back
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    k = 0;
    while (ov2 !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    check("t4_latency", k, 32'd2);
    for (int i = 0; i < 6; i++) begin
      check("t4_valid", {31'd0, ov2}, 32'd1);
      check("t4_data",  {16'd0, od2}, (i % 2 == 0) ? 32'h0000_1111 : 32'h0000_2222);
      check("t4_last",  {31'd0, ol2}, (i % 2 == 0) ? 32'd0 : 32'd1);
      step();
    end
    check("t4_done",    {31'd0, done2}, 32'd1);
    check("t4_overrun", {31'd0, orun2}, 32'd0);

    // Reset in the middle of EMIT, then a clean rerun; a start while busy is ignored
    ready4 = 1'b0;
    pulse_start4();
    wait_valid4("t5");
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_valid", {31'd0, ov4},   32'd0);
    check("t5_busy",  {31'd0, busy4}, 32'd0);
    check("t5_done",  {31'd0, done4}, 32'd0);
    check("t5_orun",  {31'd0, orun4}, 32'd0);
    check("t5_data",  {16'd0, od4},   32'd0);
    check("t5_last",  {31'd0, ol4},   32'd0);
    ready4 = 1'b1;
    step();
    check("t5_idle_stays", {31'd0, busy4}, 32'd0);
    pulse_start4();
    wait_valid4("t5r");
    start4 = 1'b1;
    check("t5r_c0_data", {16'd0, od4}, 32'h0000_AAAA);
    step();
    start4 = 1'b0;
    expect_beat4("t5r_c1", 16'hBBBB, 1'b1);
    finish_rows4("t5r", 2);
    check("t5r_done",    {31'd0, done4}, 32'd1);
    check("t5r_overrun", {31'd0, orun4}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
